// File: rtl/user_obi_reader_pkg.sv
// rtl/user_obi_reader_pkg.sv - shared types for the user-domain OBI block reader
package user_obi_reader_pkg;

  localparam int unsigned NumUserDomainManagers = 1;

  typedef enum int unsigned {
    UserObiReader = 0
  } user_manager_idx_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } reader_state_e;

  // Flat OBI channel bundles, laid out like the crossbar's request/response typedefs.
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;

endpackage

// File: rtl/user_obi_reader_fifo.sv
// rtl/user_obi_reader_fifo.sv - first-word fall-through output buffer for the block reader
module user_obi_reader_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [Width-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [Width-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(Depth):0]   o_usage
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = (AddrW+1)'(1);

  logic [Width-1:0] r_mem [Depth];
  logic [AddrW:0]   r_wptr;
  logic [AddrW:0]   r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign o_usage   = r_wptr - r_rptr;
  assign o_full    = (o_usage == (AddrW+1)'(Depth));
  assign o_empty   = (r_wptr == r_rptr);
  assign o_rdata   = r_mem[r_rptr[AddrW-1:0]];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PtrOne;
      if (w_do_pop)  r_rptr <= r_rptr + PtrOne;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AddrW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/user_obi_reader.sv
// rtl/user_obi_reader.sv - OBI manager that reads a word block and streams it out
module user_obi_reader
  import user_obi_reader_pkg::*;
#(
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned LenWidth  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [31:0]         base_addr_i,
  input  logic [LenWidth-1:0] len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic                obi_req_o,
  input  logic                obi_gnt_i,
  output logic [31:0]         obi_addr_o,
  output logic                obi_we_o,
  output logic [3:0]          obi_be_o,
  output logic [31:0]         obi_wdata_o,
  input  logic                obi_rvalid_i,
  input  logic [31:0]         obi_rdata_i,
  input  logic                obi_err_i,
  output logic [31:0]         data_o,
  output logic                valid_o,
  input  logic                ready_i
);

  localparam int unsigned UsageW = $clog2(FifoDepth) + 1;

  reader_state_e       r_state, w_state_next;
  logic [31:0]         r_addr, w_addr_next;
  logic [LenWidth-1:0] r_remaining, w_remaining_next;
  logic                r_done, w_done_next;
  logic                r_error, w_error_next;
  logic                w_req;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [31:0]         w_head;
  logic [UsageW-1:0]   w_usage;
  logic [UsageW-1:0]   w_free;
  obi_req_t            w_obi_req;
  obi_rsp_t            w_obi_rsp;

  assign w_obi_rsp = '{gnt: obi_gnt_i, rvalid: obi_rvalid_i, rdata: obi_rdata_i, err: obi_err_i};
  assign w_free    = UsageW'(FifoDepth) - w_usage;
  assign w_pop     = !w_empty && ready_i;

  // Pushes only follow a request issued with a free slot, and nothing else
  // pushes while a response is pending, so REQ never loses space it had.
  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_remaining_next = r_remaining;
    w_done_next      = 1'b0;
    w_error_next     = r_error;
    w_req            = 1'b0;
    w_push           = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_addr_next      = base_addr_i & 32'hFFFF_FFFC;
          w_remaining_next = len_i;
          w_error_next     = 1'b0;
          if (len_i == '0) w_done_next  = 1'b1;
          else             w_state_next = REQ;
        end
      end
      REQ: begin
        w_req = (w_free != '0);
        if (w_req && w_obi_rsp.gnt) begin
          w_state_next     = RSP;
          w_addr_next      = r_addr + 32'd4;
          w_remaining_next = r_remaining - LenWidth'(1);
        end
      end
      RSP: begin
        if (w_obi_rsp.rvalid) begin
          if (w_obi_rsp.err) begin
            w_error_next = 1'b1;
            w_done_next  = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_push = 1'b1;
            if (r_remaining == '0) begin
              w_done_next  = 1'b1;
              w_state_next = IDLE;
            end else begin
              w_state_next = REQ;
            end
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_remaining <= w_remaining_next;
      r_done      <= w_done_next;
      r_error     <= w_error_next;
    end
  end

  user_obi_reader_fifo #(
    .Depth (FifoDepth),
    .Width (32)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push && (!w_full || w_pop)),
    .i_wdata (w_obi_rsp.rdata),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_usage (w_usage)
  );

  assign w_obi_req = '{req: w_req, addr: r_addr, we: 1'b0, be: 4'hF, wdata: 32'h0};

  assign obi_req_o   = w_obi_req.req;
  assign obi_addr_o  = w_obi_req.addr;
  assign obi_we_o    = w_obi_req.we;
  assign obi_be_o    = w_obi_req.be;
  assign obi_wdata_o = w_obi_req.wdata;
  assign busy_o      = (r_state != IDLE);
  assign done_o      = r_done;
  assign error_o     = r_error;
  assign valid_o     = !w_empty;
  // Storage is not reset, so the head is masked until a word is present.
  assign data_o      = w_empty ? 32'h0 : w_head;

endmodule

// File: tb/tb_user_obi_reader.sv
// tb/tb_user_obi_reader.sv - directed self-checking bench for user_obi_reader
module tb_user_obi_reader;

  logic        clk = 1'b0;
  logic        rst_i, start_i, ready_i;
  logic [31:0] base_addr_i;
  logic [15:0] len_i;
  logic        busy_o, done_o, error_o;
  logic        obi_req_o, obi_gnt_i, obi_we_o, obi_rvalid_i, obi_err_i;
  logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i, data_o;
  logic [3:0]  obi_be_o;
  logic        valid_o;

  int checks = 0;
  int errors = 0;

  int          gnt_delay = 0;
  int          err_at    = -1;
  int          wait_cnt  = 0;
  int          n_gnt     = 0;
  int          rsp_idx   = 0;
  bit          hs        = 1'b0;
  logic [31:0] hs_addr   = 32'h0;
  logic [31:0] addr_log [256];
  logic [31:0] rx_q [$];

  always #5 clk = ~clk;

  user_obi_reader #(.FifoDepth(4), .LenWidth(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt_i), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
    .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o), .obi_rvalid_i(obi_rvalid_i),
    .obi_rdata_i(obi_rdata_i), .obi_err_i(obi_err_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Subordinate model: grant after gnt_delay cycles of request, respond one cycle after grant.
  initial begin
    obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0; obi_err_i = 1'b0;
    forever begin
      @(negedge clk);
      if (hs) begin
        obi_rvalid_i = 1'b1;
        obi_rdata_i  = mem_word(hs_addr);
        obi_err_i    = (rsp_idx == err_at);
        rsp_idx++;
      end else begin
        obi_rvalid_i = 1'b0; obi_rdata_i = 32'h0; obi_err_i = 1'b0;
      end
      hs = 1'b0;
      if (obi_req_o) begin
        if (wait_cnt >= gnt_delay) begin
          obi_gnt_i = 1'b1; hs = 1'b1; hs_addr = obi_addr_o;
          addr_log[n_gnt % 256] = obi_addr_o;
          n_gnt++; wait_cnt = 0;
        end else begin
          obi_gnt_i = 1'b0; wait_cnt++;
        end
      end else begin
        obi_gnt_i = 1'b0; wait_cnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_i && valid_o && ready_i) rx_q.push_back(data_o);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [31:0] b, input logic [15:0] l);
    base_addr_i = b; len_i = l; start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (done_o !== 1'b1 && cyc < budget) begin
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = 32'h0; len_i = 16'h0; ready_i = 1'b0;
    step(); step();
    checks++; if ({busy_o, done_o, error_o, obi_req_o, obi_we_o, valid_o} !== 6'b0) begin errors++;
      $display("FAIL reset_ctrl: busy/done/err/req/we/valid=%b required 000000", {busy_o, done_o, error_o, obi_req_o, obi_we_o, valid_o}); end
    checks++; if (obi_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h required 0", obi_addr_o); end
    checks++; if (obi_be_o !== 4'hF) begin errors++; $display("FAIL reset_be: got %h required f", obi_be_o); end
    checks++; if (obi_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h required 0", obi_wdata_o); end
    checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", data_o); end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int g0, r0, cyc, ndone;
    gnt_delay = 0; err_at = -1; ready_i = 1'b1; g0 = n_gnt; r0 = rx_q.size();
    start_cmd(32'h1000_0000, 16'd4);
    checks++; if ({busy_o, obi_req_o, obi_gnt_i} !== 3'b111 || obi_addr_o !== 32'h1000_0000) begin errors++;
      $display("FAIL basic_first_req: busy/req/gnt=%b addr=%h required 111 10000000", {busy_o, obi_req_o, obi_gnt_i}, obi_addr_o); end
    step();
    checks++; if ({obi_rvalid_i, valid_o, obi_req_o} !== 3'b100) begin errors++;
      $display("FAIL basic_rsp_cycle: rvalid/valid/req=%b required 100", {obi_rvalid_i, valid_o, obi_req_o}); end
    step();
    checks++; if (valid_o !== 1'b1 || data_o !== mem_word(32'h1000_0000)) begin errors++;
      $display("FAIL basic_latency: valid=%b data=%h required 1 %h", valid_o, data_o, mem_word(32'h1000_0000)); end
    wait_done(20, cyc);
    checks++; if (done_o !== 1'b1 || cyc != 6) begin errors++;
      $display("FAIL basic_done_time: done=%b after %0d cycles required 1 after 6", done_o, cyc); end
    checks++; if (busy_o !== 1'b0 || error_o !== 1'b0) begin errors++;
      $display("FAIL basic_end_flags: busy=%b error=%b required 0 0", busy_o, error_o); end
    ndone = 0;
    repeat (5) begin step(); if (done_o === 1'b1) ndone++; end
    checks++; if (ndone != 0) begin errors++; $display("FAIL basic_single_done: extra pulses %0d required 0", ndone); end
    checks++; if (n_gnt - g0 != 4) begin errors++; $display("FAIL basic_grants: got %0d required 4", n_gnt - g0); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (addr_log[(g0 + i) % 256] !== 32'h1000_0000 + 32'(4 * i)) begin errors++;
        $display("FAIL basic_addr[%0d]: got %h required %h", i, addr_log[(g0 + i) % 256], 32'h1000_0000 + 32'(4 * i)); end
    end
    checks++; if (rx_q.size() - r0 != 4) begin errors++; $display("FAIL basic_rx_count: got %0d required 4", rx_q.size() - r0); end
    else for (int i = 0; i < 4; i++) begin
      checks++; if (rx_q[r0 + i] !== mem_word(32'h1000_0000 + 32'(4 * i))) begin errors++;
        $display("FAIL basic_rx[%0d]: got %h required %h", i, rx_q[r0 + i], mem_word(32'h1000_0000 + 32'(4 * i))); end
    end
  endtask

  task automatic test_backpressure();
    int g0, r0, cyc;
    gnt_delay = 0; err_at = -1; ready_i = 1'b0; g0 = n_gnt; r0 = rx_q.size();
    start_cmd(32'h2000_0040, 16'd8);
    repeat (30) step();
    checks++; if (n_gnt - g0 != 4) begin errors++; $display("FAIL bp_grants_full: got %0d required 4", n_gnt - g0); end
    checks++; if ({obi_req_o, busy_o, valid_o} !== 3'b011) begin errors++;
      $display("FAIL bp_stalled: req/busy/valid=%b required 011", {obi_req_o, busy_o, valid_o}); end
    checks++; if (data_o !== mem_word(32'h2000_0040)) begin errors++;
      $display("FAIL bp_head: got %h required %h", data_o, mem_word(32'h2000_0040)); end
    ready_i = 1'b1;
    wait_done(100, cyc);
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL bp_done: done=%b after %0d cycles required 1", done_o, cyc); end
    repeat (6) step();
    checks++; if (n_gnt - g0 != 8) begin errors++; $display("FAIL bp_grants_total: got %0d required 8", n_gnt - g0); end
    checks++; if (rx_q.size() - r0 != 8) begin errors++; $display("FAIL bp_rx_count: got %0d required 8", rx_q.size() - r0); end
    else for (int i = 0; i < 8; i++) begin
      checks++; if (rx_q[r0 + i] !== mem_word(32'h2000_0040 + 32'(4 * i))) begin errors++;
        $display("FAIL bp_rx[%0d]: got %h required %h", i, rx_q[r0 + i], mem_word(32'h2000_0040 + 32'(4 * i))); end
    end
  endtask

  task automatic test_len0();
    int g0;
    bit saw_req;
    gnt_delay = 0; ready_i = 1'b1; g0 = n_gnt;
    start_cmd(32'h0000_0100, 16'd0);
    saw_req = obi_req_o;
    checks++; if ({done_o, busy_o} !== 2'b10) begin errors++;
      $display("FAIL len0_done: done/busy=%b required 10", {done_o, busy_o}); end
    step();
    saw_req = saw_req | obi_req_o;
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL len0_pulse_width: done=%b required 0", done_o); end
    repeat (5) begin step(); saw_req = saw_req | obi_req_o; end
    checks++; if (saw_req || n_gnt != g0) begin errors++;
      $display("FAIL len0_no_traffic: saw_req=%0d grants=%0d required 0 0", saw_req, n_gnt - g0); end
  endtask

  task automatic test_error();
    int g0, r0, cyc;
    gnt_delay = 0; ready_i = 1'b1; g0 = n_gnt; r0 = rx_q.size();
    err_at = rsp_idx + 1;
    start_cmd(32'h4000_0000, 16'd4);
    wait_done(30, cyc);
    checks++; if (done_o !== 1'b1 || cyc != 4) begin errors++;
      $display("FAIL err_done_time: done=%b after %0d cycles required 1 after 4", done_o, cyc); end
    checks++; if ({error_o, busy_o} !== 2'b10) begin errors++;
      $display("FAIL err_flags: error/busy=%b required 10", {error_o, busy_o}); end
    repeat (10) step();
    checks++; if (n_gnt - g0 != 2) begin errors++; $display("FAIL err_no_third_req: grants %0d required 2", n_gnt - g0); end
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", error_o); end
    checks++; if (rx_q.size() - r0 != 1) begin errors++; $display("FAIL err_rx_count: got %0d required 1", rx_q.size() - r0); end
    else begin
      checks++; if (rx_q[r0] !== mem_word(32'h4000_0000)) begin errors++;
        $display("FAIL err_rx_word: got %h required %h", rx_q[r0], mem_word(32'h4000_0000)); end
    end
    err_at = -1;
    start_cmd(32'h4000_0100, 16'd1);
    checks++; if ({error_o, busy_o} !== 2'b01) begin errors++;
      $display("FAIL err_cleared_by_start: error/busy=%b required 01", {error_o, busy_o}); end
    wait_done(20, cyc);
    repeat (3) step();
    checks++; if (rx_q.size() - r0 != 2 || rx_q[rx_q.size() - 1] !== mem_word(32'h4000_0100)) begin errors++;
      $display("FAIL err_next_cmd: count %0d last %h required 2 %h", rx_q.size() - r0, rx_q[rx_q.size() - 1], mem_word(32'h4000_0100)); end
  endtask

  task automatic test_gnt_delay();
    int g0, r0, cyc, stalls, unstable;
    bit prev_req, prev_gnt;
    logic [31:0] prev_addr;
    gnt_delay = 3; err_at = -1; ready_i = 1'b0; g0 = n_gnt; r0 = rx_q.size();
    start_cmd(32'h3000_0003, 16'd2);
    stalls = 0; unstable = 0; prev_req = 1'b0; prev_gnt = 1'b0; prev_addr = 32'h0; cyc = 0;
    while (done_o !== 1'b1 && cyc < 100) begin
      if (prev_req && !prev_gnt) begin
        stalls++;
        if (obi_req_o !== 1'b1 || obi_addr_o !== prev_addr) unstable++;
      end
      prev_req = obi_req_o; prev_gnt = obi_gnt_i; prev_addr = obi_addr_o;
      if (cyc == 2) begin
        start_i = 1'b1; base_addr_i = 32'h5000_0000; len_i = 16'd7;
      end else begin
        start_i = 1'b0;
      end
      ready_i = (cyc % 2 == 1);
      step();
      cyc++;
    end
    start_i = 1'b0;
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL gd_done: done=%b after %0d cycles required 1", done_o, cyc); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL gd_req_stable: unstable cycles %0d required 0", unstable); end
    checks++; if (stalls != 6) begin errors++; $display("FAIL gd_stall_cycles: got %0d required 6", stalls); end
    checks++; if (n_gnt - g0 != 2) begin errors++; $display("FAIL gd_grants: got %0d required 2", n_gnt - g0); end
    checks++; if (addr_log[g0 % 256] !== 32'h3000_0000 || addr_log[(g0 + 1) % 256] !== 32'h3000_0004) begin errors++;
      $display("FAIL gd_addrs: got %h %h required 30000000 30000004", addr_log[g0 % 256], addr_log[(g0 + 1) % 256]); end
    ready_i = 1'b1;
    repeat (5) step();
    checks++; if (rx_q.size() - r0 != 2 || rx_q[rx_q.size() - 1] !== mem_word(32'h3000_0004)) begin errors++;
      $display("FAIL gd_rx: count %0d last %h required 2 %h", rx_q.size() - r0, rx_q[rx_q.size() - 1], mem_word(32'h3000_0004)); end
    gnt_delay = 0;
  endtask

  task automatic test_wrap_reset();
    int g0, r0, cyc;
    gnt_delay = 0; err_at = -1; ready_i = 1'b1; g0 = n_gnt; r0 = rx_q.size();
    start_cmd(32'hFFFF_FFFC, 16'd2);
    wait_done(30, cyc);
    repeat (3) step();
    checks++; if (n_gnt - g0 != 2 || addr_log[g0 % 256] !== 32'hFFFF_FFFC || addr_log[(g0 + 1) % 256] !== 32'h0) begin errors++;
      $display("FAIL wrap_addrs: grants %0d addrs %h %h required 2 fffffffc 00000000", n_gnt - g0, addr_log[g0 % 256], addr_log[(g0 + 1) % 256]); end
    checks++; if (rx_q.size() - r0 != 2 || rx_q[rx_q.size() - 1] !== mem_word(32'h0)) begin errors++;
      $display("FAIL wrap_rx: count %0d last %h required 2 %h", rx_q.size() - r0, rx_q[rx_q.size() - 1], mem_word(32'h0)); end
    ready_i = 1'b0; g0 = n_gnt;
    start_cmd(32'h0000_0200, 16'd4);
    cyc = 0;
    while (n_gnt - g0 < 2 && cyc < 50) begin step(); cyc++; end
    checks++; if (n_gnt - g0 != 2) begin errors++; $display("FAIL rst_setup_grants: got %0d required 2", n_gnt - g0); end
    step();
    checks++; if ({busy_o, obi_req_o, valid_o} !== 3'b101) begin errors++;
      $display("FAIL rst_in_rsp: busy/req/valid=%b required 101", {busy_o, obi_req_o, valid_o}); end
    rst_i = 1'b1;
    step();
    checks++; if ({busy_o, done_o, error_o, obi_req_o, valid_o} !== 5'b0 || data_o !== 32'h0 || obi_addr_o !== 32'h0 || obi_be_o !== 4'hF) begin errors++;
      $display("FAIL rst_mid_cmd: busy/done/err/req/valid=%b data=%h addr=%h be=%h required 00000 0 0 f",
               {busy_o, done_o, error_o, obi_req_o, valid_o}, data_o, obi_addr_o, obi_be_o); end
    rst_i = 1'b0;
    repeat (3) step();
    checks++; if ({busy_o, obi_req_o, valid_o} !== 3'b000) begin errors++;
      $display("FAIL rst_after_release: busy/req/valid=%b required 000", {busy_o, obi_req_o, valid_o}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_len0();
    test_error();
    test_gnt_delay();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
